// File: rtl/r2b_job_scheduler.sv
// r2b_job_scheduler: time-shares one r2b converter between NUM_REQ row-stream
// requesters. A round-robin arbiter picks an owner. The scheduler then clears
// and enables the converter and passes exactly ROW rows from the owner into it.
// It waits for the converter's buffer_done, releases the grant and pulses
// job_done.
//
// Handshake: a row moves from requester g to the converter in any cycle where
// req_row_valid[g] and req_row_ready[g] are both high. req_row_ready only ever
// points at the granted requester, and only while rows are still owed.
// conv_in_valid/conv_in_data are a zero-latency copy of that accepted row.
module r2b_job_scheduler #(
   parameter int WIDTH      = 16,
   parameter int COL        = 256,
   parameter int ROW        = 2754,
   parameter int NUM_REQ    = 3,
   parameter int CLR_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_row_valid,
   input  logic [NUM_REQ*WIDTH*COL-1:0]  req_row_data,
   output logic [NUM_REQ-1:0]            req_row_ready,
   output logic [NUM_REQ-1:0]            grant,
   output logic [$clog2(NUM_REQ)-1:0]    job_id,
   output logic                          busy,
   output logic                          job_done,
   output logic                          conv_rst_n,
   output logic                          conv_en,
   output logic                          conv_in_valid,
   output logic [WIDTH*COL-1:0]          conv_in_data,
   input  logic                          conv_buffer_done,
   output logic [2:0]                    o_dbg_state
);

   localparam int RW  = WIDTH * COL;
   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(ROW + 1);
   localparam int CCW = $clog2(CLR_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_START = 3'd2,
      S_FILL  = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IDW-1:0]       r_job_id;
   logic [IDW-1:0]       r_rr;
   logic                 r_busy;
   logic                 r_job_done;
   logic                 r_conv_rst_n;
   logic                 r_conv_en;
   logic [CW-1:0]        r_row_cnt;
   logic [CCW-1:0]       r_clr_cnt;

   logic                 w_arb_hit;
   logic [IDW-1:0]       w_arb_idx;
   logic [NUM_REQ-1:0]   w_arb_onehot;
   logic                 w_in_fill;
   logic                 w_accept;
   logic [IDW-1:0]       w_rr_next;

   // Round-robin pick: first requester at or after r_rr, wrapping. The loop
   // runs from the farthest offset down so the nearest one is written last.
   always_comb begin : arb_c
      logic [IDW:0] w_sum;
      w_arb_hit    = 1'b0;
      w_arb_idx    = '0;
      w_sum        = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_sum = {1'b0, r_rr} + (IDW+1)'(i);
         if (w_sum >= (IDW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDW+1)'(NUM_REQ);
         end
         if (req[w_sum[IDW-1:0]]) begin
            w_arb_hit = 1'b1;
            w_arb_idx = w_sum[IDW-1:0];
         end
      end
      w_arb_onehot = NUM_REQ'(1) << w_arb_idx;
   end

   // Row gating toward the converter: combinational mux from the owner.
   always_comb begin
      w_in_fill     = (r_state == S_FILL);
      w_accept      = w_in_fill && req_row_valid[r_job_id];
      req_row_ready = w_in_fill ? r_grant : '0;
      conv_in_valid = w_accept;
      conv_in_data  = w_in_fill ? req_row_data[r_job_id*RW +: RW] : '0;
      w_rr_next     = (r_job_id == IDW'(NUM_REQ - 1)) ? '0 : r_job_id + IDW'(1);
   end

   // Next-state logic for the job sequence.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_arb_hit) w_next_state = S_CLEAR;
         S_CLEAR: if (r_clr_cnt == CCW'(CLR_CYCLES - 1)) w_next_state = S_START;
         S_START: w_next_state = S_FILL;
         S_FILL:  if (w_accept && (r_row_cnt == CW'(ROW - 1))) w_next_state = S_DRAIN;
         S_DRAIN: if (conv_buffer_done) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Registered outputs follow the state being entered, so they are glitch-free
   // and line up with the state they describe; plus counters and rr pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_grant      <= '0;
         r_job_id     <= '0;
         r_rr         <= '0;
         r_busy       <= 1'b0;
         r_job_done   <= 1'b0;
         r_conv_rst_n <= 1'b0;
         r_conv_en    <= 1'b0;
         r_row_cnt    <= '0;
         r_clr_cnt    <= '0;
      end else begin
         r_conv_rst_n <= (w_next_state != S_CLEAR);
         r_conv_en    <= (w_next_state == S_START) || (w_next_state == S_FILL) ||
                         (w_next_state == S_DRAIN);
         r_busy       <= (w_next_state == S_CLEAR) || (w_next_state == S_START) ||
                         (w_next_state == S_FILL)  || (w_next_state == S_DRAIN);
         r_job_done   <= (w_next_state == S_DONE);

         if ((r_state == S_IDLE) && w_arb_hit) begin
            r_grant  <= w_arb_onehot;
            r_job_id <= w_arb_idx;
         end else if (w_next_state == S_DONE) begin
            r_grant <= '0;
         end

         if (r_state == S_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + CCW'(1);
         end else begin
            r_clr_cnt <= '0;
         end

         if (r_state == S_DONE) begin
            r_row_cnt <= '0;
         end else if (w_accept) begin
            r_row_cnt <= r_row_cnt + CW'(1);
         end

         if (r_state == S_DONE) begin
            r_rr <= w_rr_next;
         end
      end
   end

   assign grant       = r_grant;
   assign job_id      = r_job_id;
   assign busy        = r_busy;
   assign job_done    = r_job_done;
   assign conv_rst_n  = r_conv_rst_n;
   assign conv_en     = r_conv_en;
   assign o_dbg_state = r_state;

endmodule
